// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and producer side of the Pipe1 register.
//
// Owns the PC, runs a req/ack handshake to instruction memory, and drives the
// Pipe1 values (toPipe1PC / toPipe1IR / toPipe1Valid) consumed by decode.
// Handles stall (one-entry hold buffer), flush/redirect (with a drop flag for
// an in-flight request) and, optionally, LM/SM expansion into LW/SW micro-ops.
//
// Configuration macro: LMSM_EXPAND_EN
//   defined   - LM/SM words are expanded one micro-op per Pipe1 cycle.
//   undefined - LM/SM pass through unchanged, lmsm_busy is tied to 0.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   imem_addr/imem_req   fetch address and request to instruction memory
//   imem_ack/imem_data   memory response (ack may coincide with req)
//   stall                decode cannot accept; Pipe1 holds
//   redirect_en/_pc      downstream control transfer and its target
//   toPipe1PC/IR/Valid   Pipe1 register contents
//   lmsm_busy            high while LM/SM micro-ops are being emitted
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  output logic [15:0] toPipe1PC,
  output logic [15:0] toPipe1IR,
  output logic        toPipe1Valid,
  output logic        lmsm_busy
);

  logic [15:0] pc_q, pc_d;
  logic [15:0] p_pc_q, p_pc_d;
  logic [15:0] p_ir_q, p_ir_d;
  logic        p_valid_q, p_valid_d;
  logic        hold_valid_q, hold_valid_d;
  logic [15:0] hold_pc_q, hold_pc_d;
  logic [15:0] hold_ir_q, hold_ir_d;
  logic        drop_q, drop_d;
  logic [15:0] drop_addr_q, drop_addr_d;
  logic        active_q;   // first cycle after reset keeps req low
  logic        in_expand;
  logic        ack_eff;
  logic        acc_en;
  logic [15:0] acc_word;
  logic [15:0] acc_pc;

`ifdef LMSM_EXPAND_EN
  typedef enum logic {S_FETCH, S_EXPAND} state_t;
  state_t      state_q, state_d;
  logic [7:0]  ex_list_q, ex_list_d;
  logic [2:0]  ex_cnt_q, ex_cnt_d;
  logic [2:0]  ex_ra_q, ex_ra_d;
  logic        ex_sm_q, ex_sm_d;
  logic        start_expand, finish_expand;
  logic [7:0]  rem;

  function automatic logic [2:0] lowest_idx(input logic [7:0] l);
    lowest_idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (l[k]) lowest_idx = 3'(k);
    end
  endfunction

  function automatic logic [15:0] micro_op(input logic sm, input logic [2:0] idx,
                                           input logic [2:0] ra, input logic [2:0] cnt);
    micro_op = {(sm ? 4'b0101 : 4'b0100), idx, ra, 3'b000, cnt};
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic: redirect always aborts an expansion
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (!redirect_en && start_expand) state_d = S_EXPAND;
      S_EXPAND: if (redirect_en || finish_expand) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  assign in_expand = (state_q == S_EXPAND);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_list_q <= 8'd0;
      ex_cnt_q  <= 3'd0;
      ex_ra_q   <= 3'd0;
      ex_sm_q   <= 1'b0;
    end else begin
      ex_list_q <= ex_list_d;
      ex_cnt_q  <= ex_cnt_d;
      ex_ra_q   <= ex_ra_d;
      ex_sm_q   <= ex_sm_d;
    end
  end
`else
  assign in_expand = 1'b0;
`endif

  // Output logic
  always_comb begin
    // While a dropped request is still in flight the address must not move,
    // even though the PC already holds the redirect target.
    imem_addr = drop_q ? drop_addr_q : pc_q;
    imem_req  = active_q && !in_expand && !hold_valid_q;
`ifdef LMSM_EXPAND_EN
    lmsm_busy = in_expand;
`else
    lmsm_busy = 1'b0;
`endif
  end

  // An ack only counts against a live request.
  assign ack_eff = imem_ack && imem_req;

  always_comb begin
    pc_d         = pc_q;
    p_pc_d       = p_pc_q;
    p_ir_d       = p_ir_q;
    p_valid_d    = p_valid_q;
    hold_valid_d = hold_valid_q;
    hold_pc_d    = hold_pc_q;
    hold_ir_d    = hold_ir_q;
    drop_d       = drop_q;
    drop_addr_d  = drop_addr_q;
    acc_en       = 1'b0;
    acc_word     = imem_data;
    acc_pc       = pc_q;
`ifdef LMSM_EXPAND_EN
    ex_list_d     = ex_list_q;
    ex_cnt_d      = ex_cnt_q;
    ex_ra_d       = ex_ra_q;
    ex_sm_d       = ex_sm_q;
    start_expand  = 1'b0;
    finish_expand = 1'b0;
    rem           = 8'd0;
`endif

    if (redirect_en) begin
      p_valid_d    = 1'b0;
      hold_valid_d = 1'b0;
      pc_d         = redirect_pc;
      // A request without its ack yet must finish at the old address and be
      // thrown away; an ack arriving now is simply discarded.
      drop_d = imem_req && !imem_ack;
      if (imem_req && !imem_ack && !drop_q) drop_addr_d = imem_addr;
    end else if (drop_q) begin
      if (ack_eff) drop_d = 1'b0;
      if (!stall) p_valid_d = 1'b0;
`ifdef LMSM_EXPAND_EN
    end else if (in_expand) begin
      if (!stall) begin
        p_pc_d    = pc_q;
        p_valid_d = 1'b1;
        p_ir_d    = micro_op(ex_sm_q, lowest_idx(ex_list_q), ex_ra_q, ex_cnt_q);
        ex_list_d = ex_list_q & (ex_list_q - 8'd1);
        ex_cnt_d  = ex_cnt_q + 3'd1;
        if (ex_list_d == 8'd0) begin
          finish_expand = 1'b1;
          pc_d          = pc_q + 16'd1;
        end
      end
`endif
    end else if (hold_valid_q) begin
      if (!stall) begin
        acc_en       = 1'b1;
        acc_word     = hold_ir_q;
        acc_pc       = hold_pc_q;
        hold_valid_d = 1'b0;
      end
    end else if (ack_eff) begin
      if (stall) begin
        hold_valid_d = 1'b1;
        hold_pc_d    = pc_q;
        hold_ir_d    = imem_data;
      end else begin
        acc_en = 1'b1;
      end
    end else if (!stall) begin
      p_valid_d = 1'b0;
    end

    if (acc_en) begin
      p_pc_d    = acc_pc;
      p_ir_d    = acc_word;
      p_valid_d = 1'b1;
      pc_d      = acc_pc + 16'd1;
`ifdef LMSM_EXPAND_EN
      if (acc_word[15:13] == 3'b011) begin
        if (acc_word[7:0] == 8'd0) begin
          p_valid_d = 1'b0;   // empty list: one bubble, then move on
        end else begin
          p_ir_d = micro_op(acc_word[12], lowest_idx(acc_word[7:0]), acc_word[11:9], 3'd0);
          rem    = acc_word[7:0] & (acc_word[7:0] - 8'd1);
          if (rem != 8'd0) begin
            // PC stays on the parent until the last micro-op leaves
            pc_d         = acc_pc;
            start_expand = 1'b1;
            ex_list_d    = rem;
            ex_cnt_d     = 3'd1;
            ex_ra_d      = acc_word[11:9];
            ex_sm_d      = acc_word[12];
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      p_pc_q       <= 16'd0;
      p_ir_q       <= 16'd0;
      p_valid_q    <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_pc_q    <= 16'd0;
      hold_ir_q    <= 16'd0;
      drop_q       <= 1'b0;
      drop_addr_q  <= 16'd0;
      active_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      p_pc_q       <= p_pc_d;
      p_ir_q       <= p_ir_d;
      p_valid_q    <= p_valid_d;
      hold_valid_q <= hold_valid_d;
      hold_pc_q    <= hold_pc_d;
      hold_ir_q    <= hold_ir_d;
      drop_q       <= drop_d;
      drop_addr_q  <= drop_addr_d;
      active_q     <= 1'b1;
    end
  end

  assign toPipe1PC    = p_pc_q;
  assign toPipe1IR    = p_ir_q;
  assign toPipe1Valid = p_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios, one task each.
// Memory model returns 16'h1000+addr (or one programmable special word) after
// a programmable number of wait cycles. A second instance with
// RESET_PC=16'hFFFF and zero-wait memory covers PC wrap-around.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect_en = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] toPipe1PC;
  logic [15:0] toPipe1IR;
  logic        toPipe1Valid;
  logic        lmsm_busy;

  logic [15:0] w_addr, w_data, w_pc, w_ir;
  logic        w_req, w_ack, w_valid, w_busy;
  logic        zero_bit = 1'b0;
  logic [15:0] zero_word = 16'h0000;

  logic [1:0]  lat = 2'd0;
  logic [1:0]  wait_cnt;
  logic        spec_en = 1'b0;
  logic [15:0] spec_addr = 16'h0000;
  logic [15:0] spec_word = 16'h0000;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .toPipe1PC(toPipe1PC), .toPipe1IR(toPipe1IR), .toPipe1Valid(toPipe1Valid),
    .lmsm_busy(lmsm_busy)
  );

  fetch_stage #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .reset(reset),
    .imem_addr(w_addr), .imem_req(w_req), .imem_ack(w_ack), .imem_data(w_data),
    .stall(zero_bit), .redirect_en(zero_bit), .redirect_pc(zero_word),
    .toPipe1PC(w_pc), .toPipe1IR(w_ir), .toPipe1Valid(w_valid),
    .lmsm_busy(w_busy)
  );

  // Instruction memory with programmable ack latency
  always_ff @(posedge clk) begin
    if (reset)         wait_cnt <= 2'd0;
    else if (imem_ack) wait_cnt <= 2'd0;
    else if (imem_req) wait_cnt <= wait_cnt + 2'd1;
  end
  assign imem_ack  = imem_req && (wait_cnt == lat);
  assign imem_data = (spec_en && imem_addr == spec_addr) ? spec_word : 16'h1000 + imem_addr;
  assign w_ack     = w_req;
  assign w_data    = 16'h1000 + w_addr;

  // Reset pulse; returns on the negedge where reset is released.
  task automatic do_reset();
    stall = 1'b0;
    redirect_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] exp_ir [4];
    exp_ir = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
    lat = 2'd0;
    spec_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0000, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL reset_pipe got pc=%h ir=%h v=%b want 0000 0000 0", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
    total++;
    if ({imem_req, lmsm_busy, imem_addr} !== {1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL reset_ctrl got req=%b busy=%b addr=%h want 0 0 0000", imem_req, lmsm_busy, imem_addr);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({imem_req, imem_addr, toPipe1Valid} !== {1'b1, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL first_req got req=%b addr=%h v=%b want 1 0000 0", imem_req, imem_addr, toPipe1Valid);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'(k), exp_ir[k], 1'b1}) begin
        bad++;
        $display("FAIL zero_wait_%0d got pc=%h ir=%h v=%b want %h %h 1", k, toPipe1PC, toPipe1IR, toPipe1Valid, 16'(k), exp_ir[k]);
      end else $display("zero_wait %0d: pc=%h ir=%h", k, toPipe1PC, toPipe1IR);
    end
  endtask

  task automatic test_stall_hold();
    lat = 2'd2;
    do_reset();
    repeat (3) @(negedge clk);        // ack for addr 0 is now on the bus
    total++;
    if ({imem_ack, imem_addr, toPipe1Valid} !== {1'b1, 16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL wait_ack got ack=%b addr=%h v=%b want 1 0000 0", imem_ack, imem_addr, toPipe1Valid);
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({imem_req, toPipe1Valid} !== 2'b00) begin
        bad++;
        $display("FAIL hold_stall_%0d got req=%b v=%b want 0 0", k, imem_req, toPipe1Valid);
      end
    end
    stall = 1'b0;
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid, imem_req, imem_addr} !== {16'h0000, 16'h1000, 1'b1, 1'b1, 16'h0001}) begin
      bad++;
      $display("FAIL hold_release got pc=%h ir=%h v=%b req=%b addr=%h want 0000 1000 1 1 0001",
               toPipe1PC, toPipe1IR, toPipe1Valid, imem_req, imem_addr);
    end else $display("hold_release: pc=%h ir=%h", toPipe1PC, toPipe1IR);
    @(negedge clk);
    total++;
    if (toPipe1Valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_once got v=%b want 0", toPipe1Valid);
    end
    repeat (2) @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0001, 16'h1001, 1'b1}) begin
      bad++;
      $display("FAIL after_hold got pc=%h ir=%h v=%b want 0001 1001 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
    stall = 1'b1;                     // stall with no ack: Pipe1 holds
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0001, 16'h1001, 1'b1}) begin
      bad++;
      $display("FAIL stall_keep got pc=%h ir=%h v=%b want 0001 1001 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
    stall = 1'b0;
  endtask

  task automatic test_redirect();
    lat = 2'd0;
    do_reset();
    repeat (6) @(negedge clk);        // addr 5 is now being requested
    lat = 2'd3;
    @(negedge clk);
    total++;
    if ({imem_addr, imem_ack, toPipe1Valid} !== {16'h0005, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL pre_redirect got addr=%h ack=%b v=%b want 0005 0 0", imem_addr, imem_ack, toPipe1Valid);
    end
    redirect_en = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect_en = 1'b0;
    total++;
    if ({imem_req, imem_addr, toPipe1Valid} !== {1'b1, 16'h0005, 1'b0}) begin
      bad++;
      $display("FAIL drop_stable got req=%b addr=%h v=%b want 1 0005 0", imem_req, imem_addr, toPipe1Valid);
    end
    @(negedge clk);                   // late ack for PC 5 arrives here
    @(negedge clk);
    total++;
    if ({imem_req, imem_addr, toPipe1Valid} !== {1'b1, 16'h0040, 1'b0}) begin
      bad++;
      $display("FAIL drop_discard got req=%b addr=%h v=%b want 1 0040 0", imem_req, imem_addr, toPipe1Valid);
    end
    lat = 2'd0;
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0040, 16'h1040, 1'b1}) begin
      bad++;
      $display("FAIL redirect_target got pc=%h ir=%h v=%b want 0040 1040 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end else $display("redirect_target: pc=%h ir=%h", toPipe1PC, toPipe1IR);
    // Redirect in the same cycle as an ack
    redirect_en = 1'b1;
    redirect_pc = 16'h0080;
    @(negedge clk);
    redirect_en = 1'b0;
    total++;
    if ({toPipe1Valid, imem_addr} !== {1'b0, 16'h0080}) begin
      bad++;
      $display("FAIL redirect_on_ack got v=%b addr=%h want 0 0080", toPipe1Valid, imem_addr);
    end
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0080, 16'h1080, 1'b1}) begin
      bad++;
      $display("FAIL after_ack_redirect got pc=%h ir=%h v=%b want 0080 1080 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
    // Redirect has priority over stall and empties the hold buffer
    stall = 1'b1;
    @(negedge clk);
    redirect_en = 1'b1;
    redirect_pc = 16'h00A0;
    @(negedge clk);
    redirect_en = 1'b0;
    stall = 1'b0;
    total++;
    if ({toPipe1Valid, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h00A0}) begin
      bad++;
      $display("FAIL redirect_over_stall got v=%b req=%b addr=%h want 0 1 00a0", toPipe1Valid, imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h00A0, 16'h10A0, 1'b1}) begin
      bad++;
      $display("FAIL after_stall_redirect got pc=%h ir=%h v=%b want 00a0 10a0 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
  endtask

  // Jump to addr via a zero-wait redirect issued on the current negedge.
  task automatic jump_to(input logic [15:0] addr);
    redirect_en = 1'b1;
    redirect_pc = addr;
    @(negedge clk);
    redirect_en = 1'b0;
  endtask

`ifdef LMSM_EXPAND_EN
  task automatic test_lmsm();
    logic [15:0] exp_ir [3];
    exp_ir = '{16'h4080, 16'h4A81, 16'h4E82};
    lat = 2'd0;
    spec_en = 1'b1;
    spec_addr = 16'h0010;
    spec_word = 16'h64A1;             // LM R2, list 1010_0001
    do_reset();
    @(negedge clk);
    jump_to(16'h0010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0010, exp_ir[k], 1'b1}) begin
        bad++;
        $display("FAIL lm_uop_%0d got pc=%h ir=%h v=%b want 0010 %h 1", k, toPipe1PC, toPipe1IR, toPipe1Valid, exp_ir[k]);
      end else $display("lm_uop %0d: ir=%h busy=%b", k, toPipe1IR, lmsm_busy);
      if (k == 0) begin
        total++;
        if ({lmsm_busy, imem_req} !== 2'b10) begin
          bad++;
          $display("FAIL lm_busy got busy=%b req=%b want 1 0", lmsm_busy, imem_req);
        end
        stall = 1'b1;                 // one stall cycle stretches the expansion
        @(negedge clk);
        stall = 1'b0;
        total++;
        if ({toPipe1IR, lmsm_busy} !== {16'h4080, 1'b1}) begin
          bad++;
          $display("FAIL lm_stall got ir=%h busy=%b want 4080 1", toPipe1IR, lmsm_busy);
        end
      end
    end
    total++;
    if ({lmsm_busy, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0011}) begin
      bad++;
      $display("FAIL lm_next got busy=%b req=%b addr=%h want 0 1 0011", lmsm_busy, imem_req, imem_addr);
    end
    // SM with an empty list
    spec_addr = 16'h0020;
    spec_word = 16'h7000;
    @(negedge clk);
    jump_to(16'h0020);
    @(negedge clk);
    total++;
    if ({toPipe1Valid, lmsm_busy, imem_addr} !== {1'b0, 1'b0, 16'h0021}) begin
      bad++;
      $display("FAIL sm_empty got v=%b busy=%b addr=%h want 0 0 0021", toPipe1Valid, lmsm_busy, imem_addr);
    end
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0021, 16'h1021, 1'b1}) begin
      bad++;
      $display("FAIL sm_empty_next got pc=%h ir=%h v=%b want 0021 1021 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
    // SM R3, list 0000_0111, redirected during the second micro-op
    spec_addr = 16'h0030;
    spec_word = 16'h7607;
    jump_to(16'h0030);
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0030, 16'h50C0, 1'b1}) begin
      bad++;
      $display("FAIL sm_uop0 got pc=%h ir=%h v=%b want 0030 50c0 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0030, 16'h52C1, 1'b1}) begin
      bad++;
      $display("FAIL sm_uop1 got pc=%h ir=%h v=%b want 0030 52c1 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
    jump_to(16'h0050);
    total++;
    if ({toPipe1Valid, lmsm_busy, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, 16'h0050}) begin
      bad++;
      $display("FAIL sm_abort got v=%b busy=%b req=%b addr=%h want 0 0 1 0050", toPipe1Valid, lmsm_busy, imem_req, imem_addr);
    end
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0050, 16'h1050, 1'b1}) begin
      bad++;
      $display("FAIL sm_abort_next got pc=%h ir=%h v=%b want 0050 1050 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
    // Reset asserted mid-expansion
    spec_addr = 16'h0010;
    spec_word = 16'h64A1;
    jump_to(16'h0010);
    @(negedge clk);
    total++;
    if (lmsm_busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_busy got busy=%b want 1", lmsm_busy);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({lmsm_busy, imem_req, toPipe1Valid, toPipe1PC, toPipe1IR} !== {1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000}) begin
      bad++;
      $display("FAIL reset_mid_expand got busy=%b req=%b v=%b pc=%h ir=%h want 0 0 0 0000 0000",
               lmsm_busy, imem_req, toPipe1Valid, toPipe1PC, toPipe1IR);
    end
    @(negedge clk);
    reset = 1'b0;
    spec_en = 1'b0;
  endtask
`else
  task automatic test_lmsm();
    lat = 2'd0;
    spec_en = 1'b1;
    spec_addr = 16'h0010;
    spec_word = 16'h64A1;
    do_reset();
    @(negedge clk);
    jump_to(16'h0010);
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid, lmsm_busy} !== {16'h0010, 16'h64A1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL lm_pass got pc=%h ir=%h v=%b busy=%b want 0010 64a1 1 0", toPipe1PC, toPipe1IR, toPipe1Valid, lmsm_busy);
    end
    @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0011, 16'h1011, 1'b1}) begin
      bad++;
      $display("FAIL lm_pass_next got pc=%h ir=%h v=%b want 0011 1011 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
    spec_en = 1'b0;
  endtask
`endif

  task automatic test_wrap();
    do_reset();
    total++;
    if ({w_req, w_addr} !== {1'b0, 16'hFFFF}) begin
      bad++;
      $display("FAIL wrap_reset got req=%b addr=%h want 0 ffff", w_req, w_addr);
    end
    @(negedge clk);
    total++;
    if ({w_req, w_addr} !== {1'b1, 16'hFFFF}) begin
      bad++;
      $display("FAIL wrap_first got req=%b addr=%h want 1 ffff", w_req, w_addr);
    end
    @(negedge clk);
    total++;
    if ({w_pc, w_ir, w_valid, w_addr} !== {16'hFFFF, 16'h0FFF, 1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL wrap_ffff got pc=%h ir=%h v=%b addr=%h want ffff 0fff 1 0000", w_pc, w_ir, w_valid, w_addr);
    end
    @(negedge clk);
    total++;
    if ({w_pc, w_ir, w_valid} !== {16'h0000, 16'h1000, 1'b1}) begin
      bad++;
      $display("FAIL wrap_0000 got pc=%h ir=%h v=%b want 0000 1000 1", w_pc, w_ir, w_valid);
    end else $display("wrap: pc=%h ir=%h", w_pc, w_ir);
  endtask

  task automatic test_async_reset();
    lat = 2'd0;
    do_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid} !== {16'h0001, 16'h1001, 1'b1}) begin
      bad++;
      $display("FAIL pre_async got pc=%h ir=%h v=%b want 0001 1001 1", toPipe1PC, toPipe1IR, toPipe1Valid);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({toPipe1PC, toPipe1IR, toPipe1Valid, imem_req, imem_addr} !== {16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000}) begin
      bad++;
      $display("FAIL async_reset got pc=%h ir=%h v=%b req=%b addr=%h want 0000 0000 0 0 0000",
               toPipe1PC, toPipe1IR, toPipe1Valid, imem_req, imem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stall_hold();
    test_redirect();
    test_lmsm();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
